axi_ram_bist_seq: RTL
=====================

AXI_RAM_BIST_SEQ -- requirements
Module: axi_ram_bist_seq

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4: AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: data width; STROBE_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have parameter BRESP_WIDTH, default 3: bresp/rresp width.
REQ-005 SHALL have parameter TIMEOUT, default 1024: idle-cycle limit per burst.
REQ-006 SHALL have port clk, in, 1: clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, in, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port start, in, 1: launch one write-then-readback test.
REQ-009 SHALL have port cfg_addr, in, ADDR_WIDTH: start byte address; low log2(STROBE_WIDTH) bits forced to 0.
REQ-010 SHALL have port cfg_len, in, 8: burst length minus 1 (AXI awlen/arlen encoding).
REQ-011 SHALL have port cfg_seed, in, DATA_WIDTH: pattern seed.
REQ-012 SHALL have port busy, out, 1: test in progress.
REQ-013 SHALL have port done, out, 1: one-cycle completion pulse.
REQ-014 SHALL have port pass, out, 1, and err_cnt, out, 8: result flag and saturating mismatch count.
REQ-015 SHALL have port timeout, out, 1: test aborted by watchdog.
REQ-016 SHALL have AW manager port group m_axi_aw{valid,id,addr,len,size,burst}, out, 1/ID/ADDR/8/3/2, with m_axi_awready in, 1.
REQ-017 SHALL have W manager port group m_axi_w{valid,data,strb,last}, out, 1/DATA/STROBE/1, with m_axi_wready in, 1.
REQ-018 SHALL have B manager port group: m_axi_bready out 1; m_axi_bvalid in 1; m_axi_bid in ID; m_axi_bresp in BRESP.
REQ-019 SHALL have AR manager port group m_axi_ar{valid,id,addr,len,size,burst}, out, with m_axi_arready in, 1.
REQ-020 SHALL have R manager port group: m_axi_rready out 1; m_axi_r{valid,id,data,resp,last} in.

Function
REQ-021 SHALL implement states IDLE, AW, W, B, AR, R, DONE, with transitions only as stated below.
REQ-022 IDLE: start=1 latches cfg_*, clears err_cnt/pass/timeout, moves to AW; start in any other state SHALL be ignored.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 All m_axi outputs SHALL be registered; a valid, once raised, SHALL hold with stable payload until its handshake (valid&ready in the same cycle).
REQ-025 AW/AR fields SHALL be: id constant 0; addr = latched cfg_addr; len = cfg_len; size = log2(STROBE_WIDTH); burst = 2'b01 (INCR).
REQ-026 AW: awvalid=1; on handshake go to W.
REQ-027 W: beat k (k = 0..cfg_len) SHALL carry wdata = cfg_seed + k, truncated to DATA_WIDTH, with wstrb all ones; wlast SHALL be 1 only on beat cfg_len.
REQ-028 W: wvalid SHALL stay 1 between beats (back-to-back allowed); handshake of the wlast beat goes to B.
REQ-029 B: bready=1; on handshake, bresp!=0 or bid!=0 SHALL increment err_cnt; then go to AR.
REQ-030 AR: arvalid=1; on handshake go to R with beat counter = 0.
REQ-031 R: rready=1; on each handshake, each of the following SHALL increment err_cnt by 1: rdata != cfg_seed + k; rresp != 0; rid != 0; rlast != (k == cfg_len).
REQ-032 R: the handshake of beat cfg_len SHALL end the burst regardless of rlast; then go to DONE.
REQ-033 err_cnt SHALL saturate at 255 and SHALL never wrap.
REQ-034 DONE: done=1 for exactly one cycle, then go to IDLE; pass = (err_cnt==0) & ~timeout.
REQ-035 err_cnt, pass and timeout SHALL hold their values until the next accepted start.
REQ-036 Watchdog: a counter SHALL clear on every handshake and on state entry, and SHALL increment otherwise in AW/W/B/AR/R.
REQ-037 When the watchdog reaches TIMEOUT: all valid/ready outputs SHALL drop next cycle, timeout=1, and the FSM SHALL go to DONE.
REQ-038 cfg_len=0 SHALL produce single-beat bursts with wlast=1 on beat 0.
REQ-039 Addresses at the top of the range SHALL be issued unmodified; wrap handling belongs to the subordinate.

Reset
REQ-040 Asserting rst_n low at any time, including mid-burst, SHALL force IDLE immediately with every output 0 (busy, done, pass, timeout, err_cnt, all valid/ready, and all payload fields).

Verification
REQ-041 Against the RAM subordinate (defaults): cfg_addr=0x10, cfg_len=3, cfg_seed=0x1234 -> writes 0x1234..0x1237, wlast on beat 3 only, done pulse, pass=1, err_cnt=0.
REQ-042 Same test with a bench-forced rdata bit flip on beat 2 -> err_cnt=1, pass=0.
REQ-043 cfg_len=0, cfg_seed=0xFFFF -> one beat 0xFFFF with wlast=1; readback pass=1; then cfg_len=1 -> beats 0xFFFF, 0x0000 (wrap).
REQ-044 awready held 0 permanently, TIMEOUT=16 -> awvalid held stable for 16 cycles, then timeout=1, pass=0, done pulse, IDLE.
REQ-045 rst_n pulsed low during beat 1 of W -> all outputs 0 immediately; a new start then runs a full test to pass=1.
REQ-046 start held high continuously -> tests repeat; start ignored while busy=1; exactly one done pulse per test.

Source files
------------

// File: rtl/axi_ram_bist_seq.sv
// AXI4 write-then-readback BIST sequencer: writes an incrementing pattern burst,
// reads it back, counts mismatches, and aborts a stalled burst through a watchdog.
module axi_ram_bist_seq #(
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int BRESP_WIDTH  = 3,
  parameter int TIMEOUT      = 1024,
  localparam int STROBE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   cfg_addr,
  input  logic [7:0]              cfg_len,
  input  logic [DATA_WIDTH-1:0]   cfg_seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [7:0]              err_cnt,
  output logic                    timeout,
  output logic                    m_axi_awvalid,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  input  logic                    m_axi_awready,
  output logic                    m_axi_wvalid,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [STROBE_WIDTH-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_wready,
  output logic                    m_axi_bready,
  input  logic                    m_axi_bvalid,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [BRESP_WIDTH-1:0]  m_axi_bresp,
  output logic                    m_axi_arvalid,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  input  logic                    m_axi_arready,
  output logic                    m_axi_rready,
  input  logic                    m_axi_rvalid,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [BRESP_WIDTH-1:0]  m_axi_rresp,
  input  logic                    m_axi_rlast
);

  localparam int SIZE       = $clog2(STROBE_WIDTH);
  localparam int WDOG_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << SIZE) - 1);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

  state_t                  r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_next;
  logic [7:0]              r_len, w_len_next;
  logic [DATA_WIDTH-1:0]   r_seed, w_seed_next;
  logic [2:0]              r_size, w_size_next;
  logic [1:0]              r_burst, w_burst_next;
  logic [STROBE_WIDTH-1:0] r_wstrb, w_wstrb_next;
  logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_next;
  logic                    r_wlast, w_wlast_next;
  logic [7:0]              r_beat, w_beat_next;
  logic [WDOG_WIDTH-1:0]   r_wdog, w_wdog_next;
  logic [7:0]              r_err_cnt, w_err_cnt_next;
  logic                    r_pass, w_pass_next;
  logic                    r_timeout, w_timeout_next;
  logic                    r_busy, r_done;
  logic                    r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;

  logic                    w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_any_hs;
  logic                    w_active;
  logic [2:0]              w_err_inc;
  logic [8:0]              w_err_sum;
  logic [DATA_WIDTH-1:0]   w_rexp;

  assign w_aw_hs  = r_awvalid & m_axi_awready;
  assign w_w_hs   = r_wvalid & m_axi_wready;
  assign w_b_hs   = r_bready & m_axi_bvalid;
  assign w_ar_hs  = r_arvalid & m_axi_arready;
  assign w_r_hs   = r_rready & m_axi_rvalid;
  assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
  assign w_active = (r_state != IDLE) && (r_state != DONE);
  assign w_rexp   = r_seed + DATA_WIDTH'(r_beat);

  always_comb begin
    w_state_next   = r_state;
    w_addr_next    = r_addr;
    w_len_next     = r_len;
    w_seed_next    = r_seed;
    w_size_next    = r_size;
    w_burst_next   = r_burst;
    w_wstrb_next   = r_wstrb;
    w_wdata_next   = r_wdata;
    w_wlast_next   = r_wlast;
    w_beat_next    = r_beat;
    w_err_cnt_next = r_err_cnt;
    w_pass_next    = r_pass;
    w_timeout_next = r_timeout;
    w_err_inc      = 3'd0;
    w_err_sum      = 9'd0;
    w_wdog_next    = '0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_addr_next    = cfg_addr & ADDR_MASK;
          w_len_next     = cfg_len;
          w_seed_next    = cfg_seed;
          w_size_next    = 3'(SIZE);
          w_burst_next   = 2'b01;
          w_wstrb_next   = '1;
          w_err_cnt_next = 8'd0;
          w_pass_next    = 1'b0;
          w_timeout_next = 1'b0;
          w_state_next   = AW;
        end
      end
      AW: begin
        if (w_aw_hs) begin
          w_state_next = W;
          w_beat_next  = 8'd0;
          w_wdata_next = r_seed;
          w_wlast_next = (r_len == 8'd0);
        end
      end
      W: begin
        if (w_w_hs) begin
          if (r_wlast) begin
            w_state_next = B;
          end else begin
            w_beat_next  = r_beat + 8'd1;
            w_wdata_next = r_wdata + DATA_WIDTH'(1);
            w_wlast_next = ((r_beat + 8'd1) == r_len);
          end
        end
      end
      B: begin
        if (w_b_hs) begin
          w_err_inc    = 3'((m_axi_bresp != '0) || (m_axi_bid != '0));
          w_state_next = AR;
        end
      end
      AR: begin
        if (w_ar_hs) begin
          w_state_next = R;
          w_beat_next  = 8'd0;
        end
      end
      R: begin
        if (w_r_hs) begin
          // Each independent defect on a beat costs one count.
          w_err_inc = 3'(m_axi_rdata != w_rexp) + 3'(m_axi_rresp != '0)
                    + 3'(m_axi_rid != '0) + 3'(m_axi_rlast != (r_beat == r_len));
          if (r_beat == r_len) w_state_next = DONE;
          else                 w_beat_next  = r_beat + 8'd1;
        end
      end
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    // Expiry fires on the cycle the counter would reach TIMEOUT.
    if (w_active && !w_any_hs && (r_wdog == WDOG_WIDTH'(TIMEOUT - 1))) begin
      w_state_next   = DONE;
      w_timeout_next = 1'b1;
    end

    w_err_sum = {1'b0, r_err_cnt} + {6'd0, w_err_inc};
    if (w_err_inc != 3'd0)
      w_err_cnt_next = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

    if ((w_state_next == DONE) && (r_state != DONE))
      w_pass_next = (w_err_cnt_next == 8'd0) && !w_timeout_next;

    if (w_active && !w_any_hs && (w_state_next == r_state))
      w_wdog_next = r_wdog + WDOG_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_seed    <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_wstrb   <= '0;
      r_wdata   <= '0;
      r_wlast   <= 1'b0;
      r_beat    <= '0;
      r_wdog    <= '0;
      r_err_cnt <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_addr    <= w_addr_next;
      r_len     <= w_len_next;
      r_seed    <= w_seed_next;
      r_size    <= w_size_next;
      r_burst   <= w_burst_next;
      r_wstrb   <= w_wstrb_next;
      r_wdata   <= w_wdata_next;
      r_wlast   <= w_wlast_next;
      r_beat    <= w_beat_next;
      r_wdog    <= w_wdog_next;
      r_err_cnt <= w_err_cnt_next;
      r_pass    <= w_pass_next;
      r_timeout <= w_timeout_next;
      r_busy    <= (w_state_next != IDLE);
      r_done    <= (w_state_next == DONE);
      r_awvalid <= (w_state_next == AW);
      r_wvalid  <= (w_state_next == W);
      r_bready  <= (w_state_next == B);
      r_arvalid <= (w_state_next == AR);
      r_rready  <= (w_state_next == R);
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_cnt       = r_err_cnt;
  assign timeout       = r_timeout;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = r_len;
  assign m_axi_awsize  = r_size;
  assign m_axi_awburst = r_burst;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wlast   = r_wlast;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = r_len;
  assign m_axi_arsize  = r_size;
  assign m_axi_arburst = r_burst;
  assign m_axi_rready  = r_rready;

endmodule
